rom_fetch_unit: RTL

- Program-counter and fetch stage that sits directly upstream of the ROM block (7-bit address, 13-bit data).
- Drives the ROM address from an internal PC and captures the returned word into an instruction register.
- Splits the captured word into opcode and operand fields.
- Presents the instruction to the downstream decoder through a valid/ready handshake, with PC load (jump) and wrap-around signalling.

---
 rtl/rom_fetch_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit
//   Program counter and fetch stage placed directly in front of the ROM.
//   The PC drives the ROM address. The returned word is captured into the
//   instruction register (IR), then split into opcode and operand fields.
//   The instruction is handed to the decoder through a valid/ready handshake.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-high; clears state, PC, IR and wrap
//   enable       1 = keep fetching; 0 = stop once the held instruction is taken
//   load         jump: PC <= load_addr on the next edge (accepted in any state)
//   load_addr    jump target
//   rom_addr     ROM address, always the registered PC
//   rom_data     ROM word, combinational from rom_addr
//   instr_valid  IR holds an instruction that has not been consumed yet
//   instr_ready  decoder accepts the instruction
//   opcode       IR[DATA_W-1 -: OPC_W]
//   operand      IR[DATA_W-OPC_W-1:0]
//   wrap         one-cycle pulse after the PC increments from all-ones to zero
module rom_fetch_unit #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 13,
    parameter int OPC_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        load_addr,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [OPC_W-1:0]         opcode,
    output logic [DATA_W-OPC_W-1:0]  operand,
    output logic                     wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc_p0;
    logic [DATA_W-1:0]   ir_p1;
    logic                wrap_q;

    // The extra top bit holds the carry out of the increment. That carry is the wrap event.
    logic [ADDR_W:0]     pc_inc;

    assign pc_inc = {1'b0, pc_p0} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = FETCH;
            FETCH:   state_nxt = VALID;
            VALID: begin
                if (instr_ready) state_nxt = enable ? FETCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc_p0  <= '0;
            ir_p1  <= '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            wrap_q <= 1'b0;

            // A jump wins over the increment and never reports a wrap,
            // even when the target is address zero.
            if (load) begin
                pc_p0 <= load_addr;
            end else if (state == FETCH) begin
                pc_p0  <= pc_inc[ADDR_W-1:0];
                wrap_q <= pc_inc[ADDR_W];
            end

            // fetch -> instruction register boundary
            if (state == FETCH) begin
                ir_p1 <= rom_data;
            end
        end
    end

    assign rom_addr    = pc_p0;
    assign instr_valid = (state == VALID);
    assign opcode      = ir_p1[DATA_W-1 -: OPC_W];
    assign operand     = ir_p1[DATA_W-OPC_W-1:0];
    assign wrap        = wrap_q;

endmodule
